// File: rtl/ecc_73_pkg.sv
// Shared constants for the 73-bit SECDED write encoder and read decoder.
// Column masks map each data bit to its Hamming codeword position.
package ecc_73_pkg;

    localparam int DATA_WIDTH   = 73;
    localparam int PARITY_WIDTH = 8;
    localparam int CNT_WIDTH    = 8;
    localparam int HAM_BITS     = 7;

    typedef logic [HAM_BITS-1:0][DATA_WIDTH-1:0] col_masks_t;

    // Data bit k sits at the k-th non-power-of-two position, starting at 3.
    function automatic col_masks_t build_masks();
        col_masks_t m;
        int pos;
        m   = '0;
        pos = 1;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            for (int i = 0; i < HAM_BITS; i++) begin
                if (pos[i]) m[i][k] = 1'b1;
            end
            pos++;
        end
        return m;
    endfunction

    localparam col_masks_t COL_MASKS = build_masks();

    localparam logic [PARITY_WIDTH-1:0] POISON_MASK = 8'h03;

    localparam logic [DATA_WIDTH-1:0] INJ_SBIT_MASK = 73'h1;
    localparam logic [DATA_WIDTH-1:0] INJ_DBIT_MASK = 73'h3;

endpackage

// File: rtl/ecc_73_enc.sv
// Combinational SECDED parity generator for one 73-bit word.
// Seven Hamming bits plus an overall parity bit on top.
module ecc_73_enc
    import ecc_73_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [PARITY_WIDTH-1:0] parity
);

    logic [HAM_BITS-1:0] ham;

    always_comb begin
        ham = '0;
        for (int i = 0; i < HAM_BITS; i++) begin
            ham[i] = ^(data & COL_MASKS[i]);
        end
    end

    assign parity = {(^data) ^ (^ham), ham};

endmodule

// File: rtl/ecc_73_enc_fault_detc.sv
// Write-side SECDED encoder with duplicated parity generation,
// mismatch poisoning/counting and one-shot error injection.
module ecc_73_enc_fault_detc
    import ecc_73_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ecc_fault_detc_en,
    input  logic                    bypass,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [PARITY_WIDTH-1:0] parity_out,
    output logic                    ecc_fault,
    output logic                    ecc_fault_sticky,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    input  logic                    fault_clr,
    input  logic                    inj_sbit,
    input  logic                    inj_dbit
);

    logic [PARITY_WIDTH-1:0] par0;
    logic [PARITY_WIDTH-1:0] par1;
    logic [DATA_WIDTH-1:0]   inj_mask;
    logic                    accept;
    logic                    fault_now;
    logic                    consume;
    logic                    arm_s;
    logic                    arm_d;

    // Two copies must survive synthesis so a single upset is observable.
    (* keep *) ecc_73_enc u0 (.data(data_in), .parity(par0));
    (* keep *) ecc_73_enc u1 (.data(data_in), .parity(par1));

    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign fault_now = ecc_fault_detc_en & ~bypass & (par0 != par1);
    assign consume   = accept & ~bypass;

    always_comb begin
        inj_mask = '0;
        if (!bypass) begin
            if (arm_d)      inj_mask = INJ_DBIT_MASK;
            else if (arm_s) inj_mask = INJ_SBIT_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            parity_out <= '0;
            ecc_fault  <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            data_out   <= data_in ^ inj_mask;
            parity_out <= bypass ? '0
                        : par0 ^ (fault_now ? POISON_MASK : '0);
            ecc_fault  <= fault_now;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
            ecc_fault  <= 1'b0;
        end
    end

    // A pulse on the consuming cycle re-arms for the following beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_s <= 1'b0;
            arm_d <= 1'b0;
        end else begin
            arm_s <= inj_sbit | (arm_s & ~consume);
            arm_d <= inj_dbit | (arm_d & ~consume);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ecc_fault_sticky <= 1'b0;
            fault_cnt        <= '0;
        end else if (fault_clr) begin
            ecc_fault_sticky <= accept & fault_now;
            fault_cnt        <= (accept & fault_now) ? CNT_WIDTH'(1) : '0;
        end else if (accept & fault_now) begin
            ecc_fault_sticky <= 1'b1;
            if (fault_cnt != '1) fault_cnt <= fault_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ecc_73_enc_fault_detc.sv
// Scoreboard bench for the 73-bit SECDED write encoder.
// Reference parity is the XOR of codeword positions of set data bits.
module tb_ecc_73_enc_fault_detc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        bypass = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [72:0] data_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [72:0] data_out;
    logic [7:0]  parity_out;
    logic        ecc_fault;
    logic        sticky;
    logic [7:0]  fault_cnt;
    logic        fault_clr = 1'b0;
    logic        inj_sbit = 1'b0;
    logic        inj_dbit = 1'b0;

    always #5 clk = ~clk;

    ecc_73_enc_fault_detc dut (
        .clk(clk), .rst(rst), .ecc_fault_detc_en(en), .bypass(bypass),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .parity_out(parity_out), .ecc_fault(ecc_fault),
        .ecc_fault_sticky(sticky), .fault_cnt(fault_cnt),
        .fault_clr(fault_clr), .inj_sbit(inj_sbit), .inj_dbit(inj_dbit)
    );

    typedef struct {
        logic [72:0] d;
        logic [7:0]  p;
        logic        f;
        int          cls;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic m_valid = 0, n_valid = 0;
    logic m_sticky = 0, n_sticky = 0;
    int   m_cnt = 0, n_cnt = 0;
    logic m_arm_s = 0, n_arm_s = 0;
    logic m_arm_d = 0, n_arm_d = 0;
    logic exp_ready = 1;
    logic flush = 0;

    task automatic check(input string nm, input logic [95:0] act,
                         input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_par(input logic [72:0] d);
        int pos;
        int syn;
        logic [7:0] p;
        pos = 1;
        syn = 0;
        for (int k = 0; k < 73; k++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[k]) syn = syn ^ pos;
            pos++;
        end
        p[6:0] = syn[6:0];
        p[7]   = (^d) ^ (^p[6:0]);
        return p;
    endfunction

    // 0 clean, 1 single (correctable), 2 double detected
    function automatic int classify(input logic [72:0] d,
                                    input logic [7:0] p);
        logic [6:0] s;
        logic       ov;
        logic [7:0] rp;
        rp = ref_par(d);
        s  = rp[6:0] ^ p[6:0];
        ov = (^d) ^ (^p);
        if (ov) return 1;
        if (s != 0) return 2;
        return 0;
    endfunction

    task automatic step(input logic v, input logic [72:0] d,
                        input logic byp, input logic e, input logic ordy,
                        input logic s, input logic db, input logic clr,
                        input logic frc, input logic rs);
        logic       acc;
        logic       flt;
        logic [7:0] p0;
        exp_t       x;
        @(posedge clk);
        m_valid  = n_valid;
        m_sticky = n_sticky;
        m_cnt    = n_cnt;
        m_arm_s  = n_arm_s;
        m_arm_d  = n_arm_d;
        if (flush) begin
            q.delete();
            flush = 0;
        end
        #1;
        rst = rs; in_valid = v; data_in = d; bypass = byp; en = e;
        out_ready = ordy; inj_sbit = s; inj_dbit = db; fault_clr = clr;
        if (frc) force dut.par1 = 8'hFF;
        else release dut.par1;
        exp_ready = ~m_valid | ordy;
        if (rs) begin
            n_valid = 0; n_sticky = 0; n_cnt = 0;
            n_arm_s = 0; n_arm_d = 0; flush = 1;
        end else begin
            acc = v & exp_ready;
            p0  = ref_par(d);
            flt = e & ~byp & frc & (p0 != 8'hFF);
            if (acc) begin
                x.d = d;
                x.f = flt;
                x.p = byp ? 8'h00 : (flt ? p0 ^ 8'h03 : p0);
                if (!byp && m_arm_d) x.d[1:0] = x.d[1:0] ^ 2'b11;
                else if (!byp && m_arm_s) x.d[0] = ~x.d[0];
                if (byp) x.cls = -1;
                else if (flt && !m_arm_d && m_arm_s) x.cls = -1;
                else if (flt || m_arm_d) x.cls = 2;
                else if (m_arm_s) x.cls = 1;
                else x.cls = 0;
                q.push_back(x);
                n_valid = 1;
            end else if (ordy) begin
                n_valid = 0;
            end
            n_arm_s = s | (m_arm_s & ~(acc & ~byp));
            n_arm_d = db | (m_arm_d & ~(acc & ~byp));
            if (clr) begin
                n_sticky = acc & flt;
                n_cnt    = (acc & flt) ? 1 : 0;
            end else if (acc & flt) begin
                n_sticky = 1;
                n_cnt    = (m_cnt == 255) ? 255 : m_cnt + 1;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            check("in_ready", {95'd0, in_ready}, {95'd0, exp_ready});
            check("out_valid", {95'd0, out_valid}, {95'd0, m_valid});
            check("sticky", {95'd0, sticky}, {95'd0, m_sticky});
            check("fault_cnt", {88'd0, fault_cnt}, 96'(m_cnt));
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: got unexpected word %h expected none",
                             data_out);
                end else begin
                    e = q[0];
                    check("data_out", {23'd0, data_out}, {23'd0, e.d});
                    check("parity_out", {88'd0, parity_out}, {88'd0, e.p});
                    check("ecc_fault", {95'd0, ecc_fault}, {95'd0, e.f});
                    if (e.cls >= 0)
                        check("decoder_class",
                              96'(classify(data_out, parity_out)), 96'(e.cls));
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                check("ecc_fault_idle", {95'd0, ecc_fault}, 96'd0);
            end
        end
    end

    function automatic logic [72:0] rnd73();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[72:0];
    endfunction

    initial begin : driver
        logic [72:0] z;
        z = '0;
        step(0, z, 0, 0, 1, 0, 0, 0, 0, 1);
        step(0, z, 0, 0, 1, 0, 0, 0, 0, 1);
        step(0, z, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_data", {23'd0, data_out}, 96'd0);
        check("reset_parity", {88'd0, parity_out}, 96'd0);
        // directed parity values
        step(1, z, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 73'h1, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 73'h1, 0, 1, 1, 0, 0, 0, 1, 0);
        step(1, 73'h1, 0, 0, 1, 0, 0, 0, 1, 0);
        step(0, z, 0, 0, 1, 0, 0, 0, 0, 0);
        // stall then drain
        for (int i = 0; i < 5; i++) step(1, rnd73(), 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, rnd73(), 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, z, 0, 1, 1, 0, 0, 0, 0, 0);
        // injection
        step(0, z, 0, 1, 1, 1, 0, 0, 0, 0);
        step(1, z, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, z, 0, 1, 1, 0, 1, 0, 0, 0);
        step(1, z, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, z, 0, 1, 1, 0, 0, 0, 0, 0);
        // bypass leaves armed flag; re-arm on consuming cycle
        step(0, z, 0, 1, 1, 1, 0, 0, 0, 0);
        step(1, rnd73(), 1, 1, 1, 0, 0, 0, 1, 0);
        step(1, z, 0, 1, 1, 1, 0, 0, 0, 0);
        step(1, z, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, z, 0, 1, 1, 0, 0, 0, 0, 0);
        // reset mid-stall
        step(1, rnd73(), 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, rnd73(), 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, z, 0, 1, 0, 0, 0, 0, 0, 0);
        // counter saturation and clear
        for (int i = 0; i < 300; i++) step(1, 73'h1, 0, 1, 1, 0, 0, 0, 1, 0);
        step(1, 73'h1, 0, 1, 1, 0, 0, 1, 1, 0);
        step(0, z, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, z, 0, 1, 1, 0, 0, 1, 0, 0);
        step(0, z, 0, 1, 1, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rnd73(),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 7) == 0, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(0, z, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("queue_empty", 96'(q.size()), 96'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_73_enc_fault_detc.md
# ecc_73_enc_fault_detc

Write-side counterpart of the FIFO's ECC read path: accepts 73-bit words over a valid/ready handshake and computes the 8-bit SECDED parity with two redundant encoder copies. It compares the copies and registers data plus parity into a single output stage that feeds the FIFO memory write port. An encoder mismatch is flagged and counted, and the stored parity is deliberately poisoned so the read-side decoder reports a double-bit error. One-shot single/double-bit error injection is provided for read-path self-test.

## Interface
- DATA_WIDTH, 73, data word width
- PARITY_WIDTH, 8, check bits: 7 Hamming plus 1 overall
- CNT_WIDTH, 8, fault counter width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- ecc_fault_detc_en  input  1  enables copy comparison
- bypass  input  1  pass data unencoded; parity_out forced 0
- in_valid  input  1  input word valid
- in_ready  output  1  stage can accept
- data_in  input  DATA_WIDTH  write data
- out_valid  output  1  registered word valid
- out_ready  input  1  memory write side accepts
- data_out  output  DATA_WIDTH  registered data, after injection
- parity_out  output  PARITY_WIDTH  registered parity
- ecc_fault  output  1  fault flag for the beat currently in the output register
- ecc_fault_sticky  output  1  set by any accepted faulty beat
- fault_cnt  output  CNT_WIDTH  saturating count of faulty beats
- fault_clr  input  1  clears sticky flag and counter
- inj_sbit  input  1  pulse: arm single-bit injection
- inj_dbit  input  1  pulse: arm double-bit injection

## Operation
- Parity, per copy: p[i] for i=0..6 is the XOR of the data bits whose codeword position has bit i set.
  - Positions are 1-based; powers of two are reserved for check bits; data bit k occupies the k-th non-power-of-two position (d0 at position 3).
  - p[7] is the XOR of all data bits and p[6:0].
- Fault: ecc_fault_detc_en=1, bypass=0, and parity of copy 0 differs from copy 1.
- parity_out = parity0 on a good beat; parity0 ^ 8'h03 on a faulty beat (poison); 0 in bypass.
- Data on a faulty beat is stored unmodified.
- Injection:
  - Each of inj_sbit and inj_dbit sets its own armed flag.
  - On the next accepted non-bypass beat: dbit flips data bits 0 and 1; otherwise sbit flips bit 0. dbit wins if both are armed.
  - The flip is applied after parity is computed.
  - Both armed flags clear on that beat. Bypass beats leave them armed.
  - A pulse arriving on the consuming cycle re-arms its flag.
- Fault counting:
  - An accepted faulty beat sets ecc_fault_sticky and increments fault_cnt, saturating at 2^CNT_WIDTH-1.
  - fault_clr alone: sticky=0, cnt=0.
  - fault_clr coinciding with an accepted faulty beat: sticky=1, cnt=1.

## Timing
- Reset values: out_valid=0, data_out=0, parity_out=0, ecc_fault=0, sticky=0, fault_cnt=0, armed flags=0.
- in_ready = ~out_valid | out_ready (combinational). in_ready=1 after reset.
- A word is accepted when in_valid & in_ready. It appears on the outputs the next cycle: latency 1, throughput 1 word/cycle.
- With out_valid & ~out_ready, the outputs hold stable and in_ready=0.
- Accept with simultaneous drain: the register reloads; there is no bubble.
- bypass and ecc_fault_detc_en are sampled at acceptance.
- ecc_fault is registered alongside its word and cleared when the stage empties.
- Reset mid-stall drops the held word. out_valid=0 on the next cycle.

## Structure
- Package ecc_73_pkg holds:
  - DATA_WIDTH and PARITY_WIDTH constants.
  - Seven 73-bit column masks for p[6:0].
  - POISON_MASK = 8'h03.
  - Injection masks: 73'h1 and 73'h3.
- The read-side decoder uses the same package masks.
- Sub-module ecc_73_enc: purely combinational parity generator, instantiated twice (u0, u1). It must not be merged or optimised away; a synthesis keep attribute is applied.

## Test plan
- Reset, then data_in=0 with out_ready=1 -> next cycle out_valid=1, parity_out=8'h00, ecc_fault=0.
- data_in=73'h1 -> parity_out=8'h83. Loopback through the decoder reports no error.
- Force u1 parity to 8'hFF with data 73'h1, en=1 -> parity_out=8'h80, ecc_fault=1, sticky=1, fault_cnt=1. Decoder reports dbit_err. With en=0, the same force gives parity 8'h83 and no fault.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable; then 1 word is accepted per cycle, and none are lost or duplicated.
- inj_sbit pulse, then data 0 -> data_out=73'h1, parity_out=8'h00, decoder corrects. inj_dbit -> data_out=73'h3, decoder flags dbit. The third beat is clean.
- 300 faulty beats -> fault_cnt saturates at 255. fault_clr on a faulty beat -> cnt=1, sticky=1.
